serial_tx_frame: RTL
====================

// Module: serial_tx_frame
// PURPOSE
//  Parallel-in, serial-out frame transmitter. Accepts one DATA_W-bit word per valid/ready handshake.
//  Shifts the word out on a single line: start bit, data LSB-first, optional parity, stop bit.
//  Transmit end of the team's serial link; the receive end samples tx_serial into
//  flip-flops on the far side. Sits between a producer (FSM/CPU side) and the pad/line.
// PARAMETERS
//  DATA_W        8   data bits per frame (1..16)
//  CLKS_PER_BIT  16  clk cycles each bit is held on tx_serial (>=1; 0 illegal)
//  PARITY_EN     0   1 = insert parity bit after data
//  PARITY_ODD    0   1 = odd parity, 0 = even (ignored when PARITY_EN=0)
// PORTS
//  clk        in   1       single clock, all logic posedge
//  rst_n      in   1       reset; one clock; reset is asynchronous and active-low
//  tx_data    in   DATA_W  word to send, sampled only on accept
//  tx_valid   in   1       producer has a word
//  tx_ready   out  1       block can accept; accept = tx_valid & tx_ready at posedge clk
//  tx_serial  out  1       serial line, idle high
//  tx_busy    out  1       frame in progress (any state but IDLE)
//  tx_done    out  1       one-cycle pulse in the last clk of the stop bit
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0,
//   bit/baud counters=0, shift reg=0. Assertion mid-frame aborts it; line goes high immediately.
//  FSM: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
//  tx_ready = (state==IDLE); registered outputs, no combinational path valid->ready.
//  Accept: latch tx_data into shift reg; compute parity = ^tx_data ^ PARITY_ODD; go START.
//  tx_serial drives the start bit (0) from the cycle after accept (latency 1 clk).
//  Each bit is held exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1;
//   the bit ends at terminal count. Counter width = max(1,$clog2(CLKS_PER_BIT)).
//  DATA: tx_serial = shreg[0]; shift right at each bit end; bit index 0..DATA_W-1; leave at DATA_W-1.
//  PARITY: tx_serial = parity bit. STOP: tx_serial = 1.
//  Frame length = (DATA_W + PARITY_EN + 2) * CLKS_PER_BIT clks.
//  tx_done=1 for exactly one clk: the final cycle of STOP. IDLE is entered the next clk.
//  Back-to-back: tx_valid held high -> accept in first IDLE cycle. Min gap = 1 idle-high clk
//   between stop bit end and next start bit.
//  tx_data/tx_valid changes while busy are ignored; no word is lost or duplicated.
//  CLKS_PER_BIT=1: one bit per clk, same FSM, no special case.
// STRUCTURE
//  serial_link_pkg: FSM state localparams (IDLE/START/DATA/PARITY/STOP, 3 bits),
//   START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1. Shared with the receiver.
//  Sub-module baud_tick_gen #(CLKS_PER_BIT): counter, clear input, one-clk tick at terminal count.
//  Top holds FSM, shift reg, bit index, parity reg, output registers.
// TESTING
//  1 DATA_W=8,CPB=4,no parity, send 0xA5 -> tx_serial 0,1,0,1,0,0,1,0,1,1 each 4 clks; done at clk 40.
//  2 PARITY_EN=1 even, 0xA5 -> parity bit 0. Odd -> 1. Frame = 44 clks.
//  3 tx_valid held high with 0x01 then 0xFF -> two frames, exactly 1 idle-high clk between them.
//    ready low throughout each frame.
//  4 rst_n low at clk 13 of a frame -> tx_serial=1, ready=1, busy=0 at once.
//    Next accepted word is sent intact.
//  5 CPB=1, 0x00 -> 0 x9 then 1, busy 10 clks, done pulse exactly 1 clk.
//  6 Change tx_data mid-frame without valid -> transmitted bits unchanged.
//    Scoreboard checks no extra frame.

Source files
------------

// File: rtl/serial_link_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : serial_link_pkg
//  Brief    : Line levels and FSM encoding shared by the serial link TX and RX.
//  Revision : 1.0
// ============================================================================
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage : serial_link_pkg
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : baud_tick_gen
//  Brief    : Bit-period counter 0..CLKS_PER_BIT-1 with a tick at terminal count.
//  Revision : 1.0
// ============================================================================
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_term = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        if (clear || (r_cnt == c_term)) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // tick_next lets the owner register outputs that coincide with the next tick
    assign tick      = (r_cnt == c_term);
    assign tick_next = (w_cnt_next == c_term);

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/serial_tx_frame.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : serial_tx_frame
//  Brief    : Parallel-in serial-out framer: start, data LSB-first, parity, stop.
//  Revision : 1.0
// ============================================================================
module serial_tx_frame
    import serial_link_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int c_idx_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DATA_W - 1);

    tx_state_t           r_state;
    tx_state_t           w_state_next;
    logic [DATA_W-1:0]   r_shreg;
    logic [DATA_W-1:0]   w_shreg_next;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_idx_w-1:0]  w_idx_next;
    logic                r_parity;
    logic                w_parity_next;
    logic                w_serial_next;
    logic                r_serial;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic                w_tick;
    logic                w_tick_next;
    logic                w_clear;

    // Counter parked at zero in IDLE so START begins a full bit period after accept
    assign w_clear = (r_state == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .tick      (w_tick),
        .tick_next (w_tick_next)
    );

    always_comb begin
        w_state_next  = r_state;
        w_shreg_next  = r_shreg;
        w_idx_next    = r_idx;
        w_parity_next = r_parity;
        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_state_next  = START;
                    w_shreg_next  = tx_data;
                    w_idx_next    = '0;
                    w_parity_next = (^tx_data) ^ (PARITY_ODD != 0);
                end
            end
            START: begin
                if (w_tick) w_state_next = DATA;
            end
            DATA: begin
                if (w_tick) begin
                    if (r_idx == c_last_idx) begin
                        w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_shreg_next = r_shreg >> 1;
                        w_idx_next   = r_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) w_state_next = STOP;
            end
            STOP: begin
                if (w_tick) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Line level is decoded from the next state so tx_serial comes straight from a flop
    always_comb begin
        w_serial_next = IDLE_LEVEL;
        case (w_state_next)
            START:   w_serial_next = START_BIT;
            DATA:    w_serial_next = w_shreg_next[0];
            PARITY:  w_serial_next = w_parity_next;
            STOP:    w_serial_next = STOP_BIT;
            default: w_serial_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg  <= '0;
            r_idx    <= '0;
            r_parity <= 1'b0;
            r_serial <= IDLE_LEVEL;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_shreg  <= w_shreg_next;
            r_idx    <= w_idx_next;
            r_parity <= w_parity_next;
            r_serial <= w_serial_next;
            r_ready  <= (w_state_next == IDLE);
            r_busy   <= (w_state_next != IDLE);
            r_done   <= (w_state_next == STOP) && w_tick_next;
        end
    end

    assign tx_ready  = r_ready;
    assign tx_serial = r_serial;
    assign tx_busy   = r_busy;
    assign tx_done   = r_done;

endmodule : serial_tx_frame
`default_nettype wire
